// File: rtl/cg_memory_arbiter_if.sv
// cg_memory_arbiter_if: requester-side and memory-side buses of the shared memory arbiter.
interface cg_memory_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 2
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            s_arvalid;
    logic [NUM_REQ-1:0]            s_arready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr;
    logic [NUM_REQ-1:0]            s_rvalid;
    logic [NUM_REQ-1:0]            s_rready;
    logic [DATA_WIDTH-1:0]         s_rdata;
    logic [NUM_REQ-1:0]            s_wvalid;
    logic [NUM_REQ-1:0]            s_wready;
    logic [NUM_REQ-1:0]            s_wen;
    logic [NUM_REQ*ADDR_WIDTH-1:0] s_waddr;
    logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata;
    logic                          m_arvalid;
    logic                          m_arready;
    logic [ADDR_WIDTH-1:0]         m_araddr;
    logic                          m_rvalid;
    logic                          m_rready;
    logic [DATA_WIDTH-1:0]         m_rdata;
    logic                          m_wvalid;
    logic                          m_wready;
    logic                          m_wen;
    logic [ADDR_WIDTH-1:0]         m_waddr;
    logic [DATA_WIDTH-1:0]         m_wdata;
    logic [IDX_W-1:0]              rd_owner;
    logic [IDX_W-1:0]              wr_owner;
    logic                          rd_busy;
    logic                          wr_busy;

    // slave: the arbiter's own view; master: requesters plus memory
    modport slave (
        input  s_arvalid, s_araddr, s_rready, s_wvalid, s_wen, s_waddr, s_wdata,
               m_arready, m_rvalid, m_rdata, m_wready,
        output s_arready, s_rvalid, s_rdata, s_wready,
               m_arvalid, m_araddr, m_rready, m_wvalid, m_wen, m_waddr, m_wdata,
               rd_owner, wr_owner, rd_busy, wr_busy
    );

    modport master (
        output s_arvalid, s_araddr, s_rready, s_wvalid, s_wen, s_waddr, s_wdata,
               m_arready, m_rvalid, m_rdata, m_wready,
        input  s_arready, s_rvalid, s_rdata, s_wready,
               m_arvalid, m_araddr, m_rready, m_wvalid, m_wen, m_waddr, m_wdata,
               rd_owner, wr_owner, rd_busy, wr_busy
    );
endinterface

// File: rtl/cg_memory_arbiter.sv
// cg_memory_arbiter: round-robin sharing of one memory port between NUM_REQ requesters,
// with independent read and write paths, one outstanding transaction each.
module cg_memory_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input logic clk,
    input logic rst,
    cg_memory_arbiter_if.slave bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_t;
    typedef enum logic {W_IDLE, W_BUSY} wr_state_t;

    rd_state_t          rd_st;
    wr_state_t          wr_st;
    logic [IDX_W-1:0]   rd_ptr, wr_ptr, rd_own, wr_own;
    logic               ar_q, aw_q, rd_busy_q, wr_busy_q;
    logic [NUM_REQ-1:0] rd_oh, wr_oh;
    logic               rd_hs;

    // Scanning downward lets the index closest to ptr overwrite the others.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [IDX_W-1:0] p);
        rr_pick = p;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (v[(int'(p) + k) % NUM_REQ]) rr_pick = IDX_W'((int'(p) + k) % NUM_REQ);
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] g);
        rr_next = IDX_W'((int'(g) + 1) % NUM_REQ);
    endfunction

    assign rd_hs = (rd_st == R_DATA) & bus.s_rready[rd_own];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_st     <= R_IDLE;
            rd_ptr    <= '0;
            rd_own    <= '0;
            ar_q      <= 1'b0;
            rd_busy_q <= 1'b0;
        end else begin
            case (rd_st)
                R_IDLE: if (|bus.s_arvalid) begin
                    rd_own    <= rr_pick(bus.s_arvalid, rd_ptr);
                    rd_st     <= R_ADDR;
                    ar_q      <= 1'b1;
                    rd_busy_q <= 1'b1;
                end
                R_ADDR: if (bus.m_arready) begin
                    rd_st <= R_DATA;
                    ar_q  <= 1'b0;
                end
                R_DATA: if (bus.m_rvalid && rd_hs) begin
                    rd_ptr    <= rr_next(rd_own);
                    rd_st     <= R_IDLE;
                    rd_busy_q <= 1'b0;
                end
                default: rd_st <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_st     <= W_IDLE;
            wr_ptr    <= '0;
            wr_own    <= '0;
            aw_q      <= 1'b0;
            wr_busy_q <= 1'b0;
        end else if (wr_st == W_IDLE) begin
            if (|bus.s_wvalid) begin
                wr_own    <= rr_pick(bus.s_wvalid, wr_ptr);
                wr_st     <= W_BUSY;
                aw_q      <= 1'b1;
                wr_busy_q <= 1'b1;
            end
        end else if (bus.m_wready) begin
            wr_ptr    <= rr_next(wr_own);
            wr_st     <= W_IDLE;
            aw_q      <= 1'b0;
            wr_busy_q <= 1'b0;
        end
    end

    always_comb begin
        rd_oh         = '0;
        rd_oh[rd_own] = 1'b1;
        wr_oh         = '0;
        wr_oh[wr_own] = 1'b1;
    end

    assign bus.s_arready = rd_oh & {NUM_REQ{ar_q & bus.m_arready}};
    assign bus.s_rvalid  = rd_oh & {NUM_REQ{(rd_st == R_DATA) & bus.m_rvalid}};
    assign bus.s_wready  = wr_oh & {NUM_REQ{aw_q & bus.m_wready}};
    assign bus.s_rdata   = bus.m_rdata;
    assign bus.m_arvalid = ar_q;
    assign bus.m_araddr  = bus.s_araddr[rd_own*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.m_rready  = rd_hs;
    assign bus.m_wvalid  = aw_q;
    assign bus.m_wen     = bus.s_wen[wr_own];
    assign bus.m_waddr   = bus.s_waddr[wr_own*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.m_wdata   = bus.s_wdata[wr_own*DATA_WIDTH +: DATA_WIDTH];
    assign bus.rd_owner  = rd_own;
    assign bus.wr_owner  = wr_own;
    assign bus.rd_busy   = rd_busy_q;
    assign bus.wr_busy   = wr_busy_q;
endmodule

// File: tb/tb_cg_memory_arbiter.sv
// tb_cg_memory_arbiter: directed checks of the memory arbiter with three requesters.
module tb_cg_memory_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    cg_memory_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REQ(3)) bus ();
    cg_memory_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REQ(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ar();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.m_arvalid && n < 10);
        chk("ar_wait", bus.m_arvalid, 1);
    endtask

    task automatic wait_w();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.m_wvalid && n < 10);
        chk("w_wait", bus.m_wvalid, 1);
    endtask

    logic [31:0] exp_a[4] = '{32'h10, 32'h20, 32'h10, 32'h20};

    initial begin
        bus.s_arvalid = '0; bus.s_araddr = '0; bus.s_rready = '0;
        bus.s_wvalid = '0; bus.s_wen = '0; bus.s_waddr = '0; bus.s_wdata = '0;
        bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = '0; bus.m_wready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_arvalid", bus.m_arvalid, 0);
        chk("rst_wvalid", bus.m_wvalid, 0);
        chk("rst_busy", {bus.rd_busy, bus.wr_busy}, 0);
        chk("rst_owners", {bus.rd_owner, bus.wr_owner}, 0);
        chk("rst_readies", {bus.s_arready, bus.s_rvalid, bus.s_wready, bus.m_rready}, 0);
        rst = 0;

        // contention: memory always ready, both requesters hold arvalid
        bus.s_araddr[0 +: 32] = 32'h10;
        bus.s_araddr[32 +: 32] = 32'h20;
        bus.s_arvalid = 3'b011;
        bus.m_arready = 1; bus.m_rvalid = 1; bus.s_rready = 3'b011;
        for (int i = 0; i < 4; i++) begin
            wait_ar();
            chk("t2_addr", bus.m_araddr, exp_a[i]);
            chk("t2_owner", bus.rd_owner, i % 2);
        end
        bus.s_arvalid = '0;
        tick();
        tick();
        bus.m_arready = 0; bus.m_rvalid = 0; bus.s_rready = '0;
        #1 chk("t2_idle", bus.rd_busy, 0);

        // single read with delayed arready
        bus.s_araddr[0 +: 32] = 32'h100;
        bus.s_arvalid = 3'b001;
        #1 chk("t1_arvalid_n", bus.m_arvalid, 0);
        tick();
        chk("t1_arvalid_n1", bus.m_arvalid, 1);
        chk("t1_araddr", bus.m_araddr, 32'h100);
        chk("t1_arready_wait", bus.s_arready, 0);
        tick();
        chk("t1_arvalid_hold", bus.m_arvalid, 1);
        bus.m_arready = 1;
        #1 chk("t1_arready", bus.s_arready, 3'b001);
        tick();
        bus.m_arready = 0; bus.s_arvalid = '0;
        bus.m_rvalid = 1; bus.m_rdata = 32'hDEADBEEF; bus.s_rready = 3'b001;
        #1;
        chk("t1_arready_pulse", {bus.s_arready, bus.m_arvalid}, 0);
        chk("t1_rvalid", bus.s_rvalid, 3'b001);
        chk("t1_rdata", bus.s_rdata, 32'hDEADBEEF);
        chk("t1_rready", bus.m_rready, 1);
        tick();
        bus.m_rvalid = 0; bus.s_rready = '0;
        #1 chk("t1_done", {bus.rd_busy, bus.s_rvalid}, 0);

        // concurrent read (req1) and write (req0)
        bus.s_araddr[32 +: 32] = 32'h40;
        bus.s_arvalid = 3'b010;
        bus.s_waddr[0 +: 32] = 32'h80;
        bus.s_wdata[0 +: 32] = 32'h55AA;
        bus.s_wen = 3'b001;
        bus.s_wvalid = 3'b001;
        tick();
        chk("t3_both_valid", {bus.m_arvalid, bus.m_wvalid}, 2'b11);
        chk("t3_araddr", bus.m_araddr, 32'h40);
        chk("t3_owners", {bus.rd_owner, bus.wr_owner}, {2'd1, 2'd0});
        chk("t3_waddr", bus.m_waddr, 32'h80);
        chk("t3_wdata", bus.m_wdata, 32'h55AA);
        chk("t3_wen", bus.m_wen, 1);
        bus.m_wready = 1; bus.m_arready = 1;
        #1;
        chk("t3_wready", bus.s_wready, 3'b001);
        chk("t3_arready", bus.s_arready, 3'b010);
        tick();
        bus.s_arvalid = '0; bus.s_wvalid = '0; bus.m_wready = 0; bus.m_arready = 0;
        bus.m_rvalid = 1; bus.m_rdata = 32'h12345678; bus.s_rready = 3'b010;
        #1;
        chk("t3_rvalid", bus.s_rvalid, 3'b010);
        chk("t3_rdata", bus.s_rdata, 32'h12345678);
        chk("t3_wr_idle", bus.wr_busy, 0);
        tick();
        bus.m_rvalid = 0; bus.s_rready = '0;

        // read backpressure from requester 0
        bus.s_araddr[0 +: 32] = 32'h200;
        bus.s_arvalid = 3'b001;
        bus.m_arready = 1;
        tick();
        bus.s_arvalid = '0;
        tick();
        bus.m_arready = 0; bus.m_rvalid = 1; bus.m_rdata = 32'hCAFEF00D; bus.s_rready = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_rready_low", bus.m_rready, 0);
            chk("t4_rvalid", bus.s_rvalid, 3'b001);
            tick();
        end
        bus.s_rready = 3'b001;
        #1 chk("t4_rready_high", bus.m_rready, 1);
        tick();
        chk("t4_idle", bus.rd_busy, 0);
        bus.m_rvalid = 0; bus.s_rready = '0;

        // reset in R_DATA while requester 2 owns the read path
        bus.s_araddr[64 +: 32] = 32'h300;
        bus.s_arvalid = 3'b100;
        bus.m_arready = 1;
        tick();
        chk("t5_owner", bus.rd_owner, 2);
        chk("t5_araddr", bus.m_araddr, 32'h300);
        bus.s_arvalid = '0;
        tick();
        bus.m_arready = 0; bus.m_rvalid = 1; bus.s_rready = 3'b100;
        #1 chk("t5_rvalid", bus.s_rvalid, 3'b100);
        #1 rst = 1;
        #1;
        chk("t5_rst_busy", bus.rd_busy, 0);
        chk("t5_rst_outs", {bus.s_rvalid, bus.m_rready, bus.m_arvalid}, 0);
        chk("t5_rst_owner", bus.rd_owner, 0);
        tick();
        rst = 0;
        bus.s_araddr[0 +: 32] = 32'h10;
        bus.s_araddr[32 +: 32] = 32'h40;
        bus.s_arvalid = 3'b011;
        bus.m_arready = 1; bus.s_rready = 3'b111;
        wait_ar();
        chk("t5_ptr_reset", bus.rd_owner, 0);
        tick();
        bus.s_arvalid = 3'b010;
        wait_ar();
        chk("t5_req1_owner", bus.rd_owner, 1);
        chk("t5_req1_addr", bus.m_araddr, 32'h40);
        bus.s_arvalid = '0;
        tick();
        tick();
        bus.m_arready = 0; bus.m_rvalid = 0; bus.s_rready = '0;
        #1 chk("t5_idle", bus.rd_busy, 0);

        // write fairness across three requesters
        bus.s_waddr = {32'hA2, 32'hA1, 32'hA0};
        bus.s_wdata = {32'hD2, 32'hD1, 32'hD0};
        bus.s_wen = 3'b111;
        bus.s_wvalid = 3'b111;
        bus.m_wready = 1;
        for (int i = 0; i < 4; i++) begin
            wait_w();
            chk("t6_owner", bus.wr_owner, i % 3);
            chk("t6_waddr", bus.m_waddr, 32'hA0 + i % 3);
            chk("t6_wdata", bus.m_wdata, 32'hD0 + i % 3);
        end
        bus.s_wvalid = '0;
        tick();
        bus.m_wready = 0;
        #1 chk("t6_idle", bus.wr_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cg_memory_arbiter.md
Name: cg_memory_arbiter

Overview:
- Shares one memory port (read-address/read-data/write channels, valid/ready handshakes) between NUM_REQ requesters.
- Read and write paths are arbitrated independently, each with its own round-robin pointer.
- Each path allows one outstanding transaction.
- Sits between core-side clients (fetch, load/store, DMA) and a single memory slave.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, address bus width.
- NUM_REQ, 2, number of requesters (>=1). IDX_W = max(1, clog2(NUM_REQ)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_arvalid  in  NUM_REQ  per-requester read-address valid.
- s_arready  out  NUM_REQ  per-requester read-address ready.
- s_araddr  in  NUM_REQ*ADDR_WIDTH  packed read addresses; requester i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- s_rvalid  out  NUM_REQ  per-requester read-data valid.
- s_rready  in  NUM_REQ  per-requester read-data ready.
- s_rdata  out  DATA_WIDTH  read data, broadcast to all requesters.
- s_wvalid  in  NUM_REQ  per-requester write valid.
- s_wready  out  NUM_REQ  per-requester write ready.
- s_wen  in  NUM_REQ  per-requester write enable qualifier.
- s_waddr  in  NUM_REQ*ADDR_WIDTH  packed write addresses.
- s_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- m_arvalid  out  1  to memory.
- m_arready  in  1  from memory.
- m_araddr  out  ADDR_WIDTH  to memory.
- m_rvalid  in  1  from memory.
- m_rready  out  1  to memory.
- m_rdata  in  DATA_WIDTH  from memory.
- m_wvalid  out  1  to memory.
- m_wready  in  1  from memory.
- m_wen  out  1  to memory.
- m_waddr  out  ADDR_WIDTH  to memory.
- m_wdata  out  DATA_WIDTH  to memory.
- rd_owner  out  IDX_W  current read grant index.
- wr_owner  out  IDX_W  current write grant index.
- rd_busy  out  1  read FSM not in R_IDLE.
- wr_busy  out  1  write FSM not in W_IDLE.

Behaviour:
- One clock (clk); reset rst is asynchronous, active-high. On reset:
  - both FSMs go to IDLE; rd_ptr = wr_ptr = 0; rd_owner = wr_owner = 0.
  - all valid/ready outputs and busy flags are 0.
  - mux outputs (m_araddr, m_waddr, m_wdata, m_wen, s_rdata) are don't-care.
- Reset mid-transaction drops the transaction with no completion. No memory-side cleanup.
- Round-robin pick:
  - Scan indices ptr, ptr+1, ... mod NUM_REQ; the first asserted valid wins.
  - After a completed transaction granted to g, ptr <= (g+1) mod NUM_REQ. The pointer changes only on completion.
- Read FSM, states R_IDLE -> R_ADDR -> R_DATA -> R_IDLE:
  - R_IDLE: if any s_arvalid, register winner in rd_owner and go to R_ADDR. All s_arready = 0.
  - R_ADDR: m_arvalid = 1; m_araddr = s_araddr[rd_owner]; s_arready[rd_owner] = m_arready, others 0. On m_arvalid & m_arready go to R_DATA.
  - R_DATA: s_rvalid[rd_owner] = m_rvalid, others 0; m_rready = s_rready[rd_owner]; s_rdata = m_rdata. On m_rvalid & m_rready: advance rd_ptr, go to R_IDLE.
  - m_rvalid arriving outside R_DATA is ignored; m_rready = 0 there.
- Write FSM, states W_IDLE -> W_BUSY -> W_IDLE:
  - W_IDLE: if any s_wvalid, register winner in wr_owner and go to W_BUSY.
  - W_BUSY: m_wvalid = 1; m_wen/m_waddr/m_wdata = requester wr_owner's fields; s_wready[wr_owner] = m_wready. On handshake: advance wr_ptr, go to W_IDLE.
- Latency:
  - Request valid in cycle N -> m_arvalid/m_wvalid in N+1, minimum.
  - Completion cycle -> next grant earliest in the cycle after; one IDLE bubble between back-to-back transactions.
- Read and write proceed concurrently and independently. A requester may hold a read and a write grant at once.
- Requesters must hold valid and address/data stable until their ready. If a requester drops valid early, the arbiter keeps the grant and m_arvalid/m_wvalid stays 1, presenting whatever that requester drives.
- Requests that arrive in the same cycle as a grant decision but lose wait. Losing requesters see ready = 0.
- NUM_REQ = 1: the pointer stays 0; behaviour is otherwise identical.

Test Plan:
- Single read: req0 araddr=0x100, memory arready after 2 cycles, rdata=0xDEADBEEF -> m_arvalid rises 1 cycle after s_arvalid[0]; s_arready[0] pulses once; s_rvalid[0] with 0xDEADBEEF; s_rvalid[1] never asserts.
- Contention: req0 and req1 both hold arvalid continuously, addrs 0x10/0x20, memory always ready -> m_araddr sequence 0x10,0x20,0x10,0x20; rd_owner alternates 0,1,0,1.
- Concurrent read+write: req1 read 0x40 while req0 writes wdata=0x55AA at 0x80 -> both m_arvalid and m_wvalid high in the same cycle; s_wready[0] only; the read data routes to req1.
- Read backpressure: m_rvalid held while s_rready[0]=0 for 3 cycles -> m_rready = 0 for those cycles; completes on the cycle s_rready[0]=1; R_IDLE on the next cycle.
- Reset mid-read: assert rst in R_DATA -> all outputs 0 immediately (asynchronously); rd_ptr = 0; after release, a new req1 read is granted normally.
- Write pointer fairness: 3 requesters with wvalid held; writes complete in order 0,1,2,0; wr_ptr wraps 2 -> 0.
